// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill controller: state encodings,
// default block geometry and the block-base mask helper.
package cache_pkg;

    typedef enum logic [1:0] {
        FILL_IDLE   = 2'b00,
        FILL_ACTIVE = 2'b01
    } fill_state_t;

    localparam int CACHE_BLOCK_WORDS = 8;
    localparam int BLOCK_BYTES       = CACHE_BLOCK_WORDS * 2;
    localparam int OFFSET_BITS       = $clog2(BLOCK_BYTES);

    // All-ones mask with the low offset_bits cleared; AND with a byte address to get its block base.
    function automatic logic [31:0] block_mask(input int unsigned offset_bits);
        block_mask = ~((32'd1 << offset_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_fill_counter.sv
// Clearable, enable-gated up-counter that saturates at MAX, with a terminal-count
// flag that asserts when the count equals TC.
module fill_counter #(
    parameter int W   = 4,
    parameter int MAX = 8,
    parameter int TC  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] TC_V  = W'(TC);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_V);

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling controller: on a miss, issues pipelined reads for one cache block,
// streams returning words into the data array, then pulses the tag write.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = CACHE_BLOCK_WORDS,
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array
);

    localparam int OFF_BITS = $clog2(BLOCK_WORDS * 2);
    localparam int CNT_W    = $clog2(BLOCK_WORDS) + 1;
    localparam logic [31:0] MASK32 = block_mask(OFF_BITS);

    // The FSM counts responses, so latency only constrains legal configurations.
    if ((BLOCK_WORDS < 2) || ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) ||
        (MEM_LATENCY < 1) || (ADDR_W > 32)) begin : g_param_check
        $error("cache_fill_fsm: unsupported parameter combination");
    end

    fill_state_t       state, state_next;
    logic [ADDR_W-1:0] block_base;
    logic              start;
    logic              rcv_en;
    logic [CNT_W-1:0]  issue_cnt, rcv_cnt;
    logic              issue_done, rcv_last;
    logic [ADDR_W-1:0] issue_off, rcv_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL_IDLE;
            block_base <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                block_base <= miss_address & MASK32[ADDR_W-1:0];
            end
        end
    end

    // Issue counter saturates at BLOCK_WORDS; receive counter flags the last word.
    fill_counter #(.W(CNT_W), .MAX(BLOCK_WORDS), .TC(BLOCK_WORDS)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .en    (mem_read_en),
        .count (issue_cnt),
        .tc    (issue_done)
    );

    fill_counter #(.W(CNT_W), .MAX(BLOCK_WORDS), .TC(BLOCK_WORDS - 1)) u_rcv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .en    (rcv_en),
        .count (rcv_cnt),
        .tc    (rcv_last)
    );

    assign issue_off = ADDR_W'(issue_cnt) << 1;
    assign rcv_off   = ADDR_W'(rcv_cnt) << 1;
    assign rcv_en    = (state == FILL_ACTIVE) && memory_data_valid;
    assign fill_data = memory_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next       = state;
        start            = 1'b0;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_address     = '0;
        write_tag_array  = 1'b0;
        unique case (state)
            FILL_IDLE: begin
                // Busy in the miss cycle itself so the CPU stalls immediately.
                if (miss_detected) begin
                    fsm_busy   = 1'b1;
                    start      = 1'b1;
                    state_next = FILL_ACTIVE;
                end
            end
            FILL_ACTIVE: begin
                fsm_busy         = 1'b1;
                mem_read_en      = !issue_done;
                memory_address   = block_base + issue_off;
                write_data_array = memory_data_valid;
                fill_address     = block_base + rcv_off;
                if (memory_data_valid && rcv_last) begin
                    write_tag_array = 1'b1;
                    state_next      = FILL_IDLE;
                end
            end
            default: state_next = FILL_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed self-checking bench for cache_fill_fsm: regular, irregular, wrapped,
// reset-aborted and back-to-back fills, each cycle compared against hand-derived values.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_address;
    logic [15:0] fill_data;
    logic        write_tag_array;

    int n_vec  = 0;
    int n_miss = 0;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_address      (fill_address),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle with no miss; an optional spurious response must be ignored.
    task automatic idle_step(input string tag, input logic valid, input logic [15:0] data);
        miss_detected     = 1'b0;
        memory_data_valid = valid;
        memory_data       = data;
        @(negedge clk);
        chk({tag, " busy"}, 16'(fsm_busy), 16'd0);
        chk({tag, " rd_en"}, 16'(mem_read_en), 16'd0);
        chk({tag, " wda"}, 16'(write_data_array), 16'd0);
        chk({tag, " tag"}, 16'(write_tag_array), 16'd0);
        next_cycle();
    endtask

    task automatic all_zero(input string tag);
        @(negedge clk);
        chk({tag, " busy"}, 16'(fsm_busy), 16'd0);
        chk({tag, " rd_en"}, 16'(mem_read_en), 16'd0);
        chk({tag, " maddr"}, memory_address, 16'd0);
        chk({tag, " wda"}, 16'(write_data_array), 16'd0);
        chk({tag, " faddr"}, fill_address, 16'd0);
        chk({tag, " fdata"}, fill_data, 16'd0);
        chk({tag, " tag"}, 16'(write_tag_array), 16'd0);
    endtask

    // Drives one fill starting with the miss cycle (cycle 0). Requests are expected in
    // cycles 1..8; response k arrives at cycle 5+k plus accumulated gaps when irregular.
    // hold_miss keeps miss_detected high and switches the address to alt_addr from cycle 3.
    // abort >= 0 asserts rst during that cycle and returns after it.
    task automatic run_fill(input string name, input logic [15:0] maddr,
                            input logic [15:0] base, input logic [15:0] data_base,
                            input bit irregular, input bit hold_miss,
                            input logic [15:0] alt_addr, input int abort);
        int resp[8];
        int gaps[8] = '{0, 2, 1, 3, 0, 0, 2, 1};
        int k;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) resp[i] = 5 + (irregular ? gaps[0] : 0);
            else        resp[i] = resp[i-1] + 1 + (irregular ? gaps[i] : 0);
        end
        for (int c = 0; c <= resp[7]; c++) begin
            k = -1;
            for (int i = 0; i < 8; i++) if (resp[i] == c) k = i;
            miss_detected     = (c == 0) || hold_miss;
            miss_address      = (hold_miss && c >= 3) ? alt_addr : maddr;
            memory_data_valid = (k >= 0);
            memory_data       = (k >= 0) ? data_base + 16'(k) : 16'h5A5A;
            rst               = (c == abort);
            @(negedge clk);
            chk($sformatf("%s c%0d busy", name, c), 16'(fsm_busy), 16'd1);
            chk($sformatf("%s c%0d rd_en", name, c), 16'(mem_read_en),
                16'((c >= 1) && (c <= 8)));
            if ((c >= 1) && (c <= 8))
                chk($sformatf("%s c%0d maddr", name, c), memory_address, base + 16'(2 * (c - 1)));
            chk($sformatf("%s c%0d wda", name, c), 16'(write_data_array), 16'(k >= 0));
            if (k >= 0) begin
                chk($sformatf("%s c%0d faddr", name, c), fill_address, base + 16'(2 * k));
                chk($sformatf("%s c%0d fdata", name, c), fill_data, data_base + 16'(k));
            end
            chk($sformatf("%s c%0d tag", name, c), 16'(write_tag_array), 16'(k == 7));
            next_cycle();
            rst = 1'b0;
            if (c == abort) return;
        end
    endtask

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data       = 16'h0;
        memory_data_valid = 1'b0;
        next_cycle();
        all_zero("reset");
        next_cycle();
        rst = 1'b0;

        // Basic fill at 0x1236, then the stall must drop in cycle 13.
        run_fill("basic", 16'h1236, 16'h1230, 16'hA000, 1'b0, 1'b0, 16'h0, -1);
        idle_step("basic c13", 1'b0, 16'h0);

        // Miss held high with address change mid-fill; second fill starts right after
        // completion at 0x5550 and is aborted by reset in its cycle 6.
        run_fill("hold", 16'h1236, 16'h1230, 16'hA000, 1'b0, 1'b1, 16'h5550, -1);
        run_fill("second", 16'h5550, 16'h5550, 16'hB000, 1'b0, 1'b0, 16'h0, 6);
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
        all_zero("post_rst");
        next_cycle();
        for (int i = 0; i < 3; i++) idle_step($sformatf("post_rst idle%0d", i), 1'b1, 16'hB00F);

        run_fill("fresh", 16'h0040, 16'h0040, 16'hC000, 1'b0, 1'b0, 16'h0, -1);
        idle_step("fresh done", 1'b0, 16'h0);

        run_fill("wrap", 16'hFFFA, 16'hFFF0, 16'h0F00, 1'b0, 1'b0, 16'h0, -1);
        idle_step("wrap done", 1'b0, 16'h0);
        idle_step("spurious", 1'b1, 16'h1234);

        run_fill("irreg", 16'h2468, 16'h2460, 16'hD000, 1'b1, 1'b0, 16'h0, -1);
        idle_step("irreg done", 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the CPU's memory ports (instruction and data) and a multi-cycle main memory.
- On a cache miss it fetches one 16-byte block (8 x 16-bit words) with pipelined reads.
- It drives the cache data-array write strobes word by word, then writes the tag array once.
- It holds the pipeline stalled through fsm_busy until the fill completes.

Parameters:
- BLOCK_WORDS, 8: words per cache block. Must be a power of two; the block is BLOCK_WORDS*2 bytes.
- MEM_LATENCY, 4: cycles from a main-memory read request to memory_data_valid. Informational only; the FSM counts responses, not cycles.
- ADDR_W, 16: byte-address width.
- DATA_W, 16: word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  cache reports a miss this cycle.
- miss_address  in  ADDR_W  byte address that missed.
- memory_data  in  DATA_W  read data returning from main memory.
- memory_data_valid  in  1  memory_data is valid this cycle.
- fsm_busy  out  1  stall request to the CPU.
- mem_read_en  out  1  read request to main memory this cycle.
- memory_address  out  ADDR_W  byte address of the current read request.
- write_data_array  out  1  write memory_data into the cache data array this cycle.
- fill_address  out  ADDR_W  byte address of the word being written to the data array.
- fill_data  out  DATA_W  equals memory_data (pass-through).
- write_tag_array  out  1  one-cycle pulse: write the tag and valid bit for the block base.

Behaviour:
- States are IDLE and FILL, with a 2-bit encoding from the package. Reset state is IDLE.
- Reset values: all outputs 0; issue_cnt, rcv_cnt and block_base cleared.
- Reset takes effect at the next edge, including mid-fill. A partial fill is abandoned and no tag write occurs.
- Block base: block_base = miss_address with the low log2(BLOCK_WORDS*2) bits zeroed (0xFFF0 mask by default). Latched on the IDLE->FILL edge. Later changes to miss_address are ignored.
- fsm_busy = (state==FILL) | (state==IDLE & miss_detected). It is combinational so the CPU stalls in the miss cycle itself.
- IDLE -> FILL: on a clock edge with miss_detected=1. Set issue_cnt=0 and rcv_cnt=0.
- Issue side (FILL):
  - mem_read_en = (issue_cnt < BLOCK_WORDS).
  - memory_address = block_base + 2*issue_cnt.
  - issue_cnt increments every cycle while mem_read_en=1, saturating at BLOCK_WORDS.
  - One request is issued per cycle; there is no backpressure.
- Receive side (FILL):
  - write_data_array = memory_data_valid.
  - fill_address = block_base + 2*rcv_cnt.
  - rcv_cnt increments on each valid.
  - Responses return in request order.
- Completion: valid with rcv_cnt==BLOCK_WORDS-1 gives write_data_array=1 and write_tag_array=1 in the same cycle, and next state is IDLE. fsm_busy drops the following cycle.
- Timing with default parameters, miss sampled at edge 0:
  - Requests in cycles 1..8.
  - Data in cycles 5..12; tag written in cycle 12.
  - IDLE and fsm_busy=0 from cycle 13: 13 stall cycles including the miss cycle.
- Ignored inputs:
  - memory_data_valid in IDLE.
  - miss_detected during FILL, and on the completion cycle. A new miss needs a new IDLE cycle and is sampled the cycle after completion.
- Address wrap: block_base + 2*k is computed modulo 2^ADDR_W. A block at 0xFFF0 requests 0xFFF0..0xFFFE.
- Arithmetic: counters are log2(BLOCK_WORDS)+1 bits. Address offsets are zero-extended to ADDR_W before adding.

Decomposition:
- Shared package cache_pkg holds:
  - state encodings (FILL_IDLE=2'b00, FILL_ACTIVE=2'b01);
  - BLOCK_BYTES and OFFSET_BITS constants;
  - the block-base mask function.
- One sub-module, fill_counter: a clearable, enable-gated, saturating up-counter with a terminal-count output. It is instantiated twice, for issue and for receive.

Test Plan:
- Reset, then miss_address=0x1236 at cycle 0 -> fsm_busy=1 in cycle 0; memory_address 0x1230,0x1232,...,0x123E in cycles 1..8 with mem_read_en=1; mem_read_en=0 from cycle 9.
- Memory model with latency 4 returning data 0xA000+k -> write_data_array in cycles 5..12 with fill_address 0x1230+2k and fill_data 0xA000+k; write_tag_array only in cycle 12; fsm_busy=0 in cycle 13.
- miss_detected held high throughout, with miss_address changed to 0x5550 mid-fill -> all requests stay in block 0x1230; second fill starts the cycle after completion at block 0x5550.
- rst asserted in cycle 6 of a fill -> next cycle all outputs 0 and state IDLE; no write_tag_array; a fresh miss at 0x0040 fills cleanly.
- Miss at 0xFFFA -> requests 0xFFF0..0xFFFE, no wrap past 0xFFFE; spurious memory_data_valid in IDLE -> no write_data_array.
- Irregular response spacing (gaps of 0-3 cycles) -> exactly 8 data writes in order and the tag pulse on the 8th.
